// File: rtl/parity_stream_gen_pkg.sv
// parity_stream_gen_pkg: shared framing state encoding and lane slice width helper
package parity_stream_gen_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
  localparam int PAR_W = 1;
  function automatic int slice_w(input int dw);
    return dw + PAR_W;
  endfunction
endpackage

// File: rtl/lane_parity.sv
// lane_parity: combinational odd/even parity of a single data lane
module lane_parity #(
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b1
) (
  input  logic [DATA_W-1:0] data,
  output logic              par
);
  // odd parity inverts the XOR reduction so lane plus parity holds an odd number of ones
  always_comb par = ODD ? ~^data : ^data;
endmodule

// File: rtl/parity_stream_gen.sv
// parity_stream_gen: per-lane parity append with framing check; STAT_CNT_EN adds packet/error counters
module parity_stream_gen
  import parity_stream_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 1,
  parameter bit ODD    = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst_n,
  input  logic                              in_sop,
  input  logic                              in_eop,
  input  logic                              in_vld,
  input  logic [LANES*DATA_W-1:0]           in_data,
  output logic                              out_sop,
  output logic                              out_eop,
  output logic                              out_vld,
  output logic [LANES*slice_w(DATA_W)-1:0]  out_data,
  output logic                              frm_err
`ifdef STAT_CNT_EN
  ,
  input  logic                              clr_cnt,
  output logic [CNT_W-1:0]                  pkt_cnt,
  output logic [CNT_W-1:0]                  err_cnt
`endif
);
  localparam int SW = slice_w(DATA_W);
  logic [LANES-1:0]    par;
  logic [LANES*SW-1:0] enc;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_parity #(.DATA_W(DATA_W), .ODD(ODD)) u_par (
      .data(in_data[k*DATA_W +: DATA_W]),
      .par (par[k])
    );
    assign enc[k*SW +: SW] = {par[k], in_data[k*DATA_W +: DATA_W]};
  end
  state_e              state_q, state_d;
  logic                sop_q, sop_d, eop_q, eop_d, vld_q, vld_d, err_q, err_d;
  logic [LANES*SW-1:0] data_q, data_d;
  logic                busy, open;
  // next beat register contents and framing transition; framing only advances on valid beats
  always_comb begin
    busy    = state_q == ST_BUSY;
    open    = in_sop | busy;
    sop_d   = in_sop & in_vld;
    eop_d   = in_eop & in_vld;
    vld_d   = in_vld;
    data_d  = in_vld ? enc : data_q;
    err_d   = in_vld & (busy ? in_sop : ~in_sop);
    state_d = in_vld ? ((open & ~in_eop) ? ST_BUSY : ST_IDLE) : state_q;
  end
  // output beat register and framing state
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end
  assign out_sop  = sop_q;
  assign out_eop  = eop_q;
  assign out_vld  = vld_q;
  assign out_data = data_q;
  assign frm_err  = err_q;
`ifdef STAT_CNT_EN
  logic             done;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
  // saturating counters; a packet is done when an eop closes a frame that was opened by a sop
  always_comb begin
    done      = in_vld & in_eop & open;
    pkt_cnt_d = clr_cnt ? '0 : pkt_cnt_q + CNT_W'(done & ~&pkt_cnt_q);
    err_cnt_d = clr_cnt ? '0 : err_cnt_q + CNT_W'(err_d & ~&err_cnt_q);
  end
  // counters registered alongside the output beat
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_parity_stream_gen.sv
// tb_parity_stream_gen: scoreboard bench, two configurations driven from one randomized stream
module tb_parity_stream_gen;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n, in_sop, in_eop, in_vld, clr_cnt;
  logic [15:0] in_data;
  logic        o_sop, o_eop, o_vld, o_err;
  logic [17:0] o_data;
  logic        p_sop, p_eop, p_vld, p_err;
  logic [8:0]  p_data;
  logic [CW-1:0] o_pc, o_ec, p_pc, p_ec;
  always #5 sys_clk = ~sys_clk;
  parity_stream_gen #(.DATA_W(8), .LANES(2), .ODD(1'b0), .CNT_W(CW)) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_sop(in_sop), .in_eop(in_eop),
    .in_vld(in_vld), .in_data(in_data), .out_sop(o_sop), .out_eop(o_eop),
    .out_vld(o_vld), .out_data(o_data), .frm_err(o_err)
`ifdef STAT_CNT_EN
    , .clr_cnt(clr_cnt), .pkt_cnt(o_pc), .err_cnt(o_ec)
`endif
  );
  parity_stream_gen #(.DATA_W(8), .LANES(1), .ODD(1'b1), .CNT_W(CW)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_sop(in_sop), .in_eop(in_eop),
    .in_vld(in_vld), .in_data(in_data[7:0]), .out_sop(p_sop), .out_eop(p_eop),
    .out_vld(p_vld), .out_data(p_data), .frm_err(p_err)
`ifdef STAT_CNT_EN
    , .clr_cnt(clr_cnt), .pkt_cnt(p_pc), .err_cnt(p_ec)
`endif
  );
`ifndef STAT_CNT_EN
  assign o_pc = '0;
  assign o_ec = '0;
  assign p_pc = '0;
  assign p_ec = '0;
`endif
  typedef struct {
    bit        vld, sop, eop, err;
    logic [17:0] d0;
    logic [8:0]  d1;
    int        pc, ec;
  } rec_t;
  rec_t sbq[$];
  int asserts = 0, fails = 0;
  bit in_pkt = 0;
  int pc = 0, ec = 0;
  logic [17:0] hd0 = '0;
  logic [8:0]  hd1 = '0;
  function automatic logic [8:0] enc_lane(input logic [7:0] d, input bit odd);
    bit ones_odd;
    ones_odd = ($countones(d) % 2) == 1;
    return {odd ? !ones_odd : ones_odd, d};
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic step(input bit rn, input bit v, input bit s, input bit e, input bit clr,
                      input logic [15:0] d);
    rec_t r;
    bit done, err;
    sys_rst_n = rn; in_vld = v; in_sop = s; in_eop = e; clr_cnt = clr; in_data = d;
    if (!rn) begin
      in_pkt = 0; pc = 0; ec = 0; hd0 = '0; hd1 = '0;
      r = '{vld: 0, sop: 0, eop: 0, err: 0, d0: '0, d1: '0, pc: 0, ec: 0};
    end else begin
      err  = v && (in_pkt ? s : !s);
      done = v && e && (s || in_pkt);
      if (v) begin
        in_pkt = (s || in_pkt) && !e;
        hd0 = {enc_lane(d[15:8], 1'b0), enc_lane(d[7:0], 1'b0)};
        hd1 = enc_lane(d[7:0], 1'b1);
      end
      pc = clr ? 0 : (done && pc < CMAX) ? pc + 1 : pc;
      ec = clr ? 0 : (err && ec < CMAX) ? ec + 1 : ec;
      r = '{vld: v, sop: s && v, eop: e && v, err: err, d0: hd0, d1: hd1, pc: pc, ec: ec};
    end
    sbq.push_back(r);
    @(negedge sys_clk);
  endtask
  initial begin
    rec_t r;
    forever begin
      @(posedge sys_clk);
      #1;
      if (sbq.size() > 0) begin
        r = sbq.pop_front();
        chk("out_vld", o_vld, r.vld);
        chk("out_sop", o_sop, r.sop);
        chk("out_eop", o_eop, r.eop);
        chk("frm_err", o_err, r.err);
        chk("out_data2", o_data, r.d0);
        chk("out_data1", p_data, r.d1);
        chk("frm_err1", p_err, r.err);
        chk("out_vld1", {p_vld, p_sop, p_eop}, {r.vld, r.sop, r.eop});
`ifdef STAT_CNT_EN
        chk("pkt_cnt", o_pc, r.pc);
        chk("err_cnt", o_ec, r.ec);
        chk("pkt_cnt1", p_pc, r.pc);
        chk("err_cnt1", p_ec, r.ec);
`endif
      end
    end
  end
  initial begin
    step(0, 1, 1, 1, 0, 16'hffff);
    step(0, 0, 0, 0, 0, 16'h0);
    step(1, 1, 1, 1, 0, 16'h0000);
    step(1, 1, 1, 1, 0, 16'h0001);
    step(1, 1, 1, 1, 0, 16'h00ff);
    step(1, 1, 1, 1, 0, 16'h0301);
    step(1, 0, 0, 0, 1, 16'h0);
    step(1, 1, 1, 0, 0, 16'h1234);
    step(1, 1, 0, 0, 0, 16'h5678);
    step(1, 1, 0, 0, 0, 16'h9abc);
    step(1, 1, 0, 1, 0, 16'hdef0);
    step(1, 1, 1, 1, 0, 16'h0f0f);
    step(1, 1, 0, 0, 0, 16'haaaa);
    step(1, 1, 1, 0, 0, 16'h1111);
    step(1, 1, 1, 0, 0, 16'h2222);
    step(1, 1, 0, 1, 0, 16'h3333);
    step(1, 0, 1, 0, 0, 16'h4444);
    step(1, 1, 1, 0, 0, 16'h5555);
    step(1, 0, 1, 1, 0, 16'h6666);
    step(1, 1, 0, 1, 1, 16'h7777);
    step(1, 1, 1, 0, 0, 16'h8888);
    step(1, 1, 0, 0, 0, 16'h9999);
    step(0, 1, 0, 0, 0, 16'hbbbb);
    step(1, 1, 0, 0, 0, 16'hcccc);
    for (int i = 0; i < 10; i++) step(1, 1, 1, 1, 0, 16'(i * 37));
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 16'(i * 91));
    step(1, 0, 0, 0, 1, 16'h0);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3, 16'($urandom));
    repeat (2) @(posedge sys_clk);
    #2;
    chk("sb_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
